// File: rtl/ppu_pkg.sv
// Shared types and address map for the PPU memory responder.
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } ppu_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } dma_state_e;

    localparam logic [15:0] VRAM_BASE    = 16'h8000;
    localparam logic [15:0] VRAM_END     = 16'h9FFF;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_END      = 16'hFE9F;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int unsigned VRAM_LEN     = 8192;
    localparam int unsigned OAM_LEN      = 160;
    localparam logic [7:0]  OAM_LAST     = 8'(OAM_LEN - 1);

    function automatic logic in_vram(input logic [15:0] a);
        return (a >= VRAM_BASE) && (a <= VRAM_END);
    endfunction

    function automatic logic in_oam(input logic [15:0] a);
        return (a >= OAM_BASE) && (a <= OAM_END);
    endfunction

endpackage

// File: rtl/ppu_mem_responder_dma.sv
// OAM DMA engine: 160-byte copy from {src,8'h00} into OAM, one byte per cycle,
// source data arriving one cycle after each read strobe.
module oam_dma_engine
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  src_i,
    input  logic [7:0]  dma_data_i,
    output logic        dma_rd_o,
    output logic [15:0] dma_addr_o,
    output logic        active_o,
    output logic        oam_we_o,
    output logic [7:0]  oam_idx_o,
    output logic [7:0]  oam_wdata_o
);

    dma_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_q, src_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        src_d       = src_q;
        dma_rd_o    = 1'b0;
        dma_addr_o  = '0;
        oam_we_o    = 1'b0;
        oam_idx_o   = '0;
        oam_wdata_o = dma_data_i;

        case (state_q)
            IDLE: ;
            START: begin
                state_d = XFER;
                idx_d   = '0;
            end
            XFER: begin
                dma_rd_o   = 1'b1;
                dma_addr_o = {src_q, idx_q};
                // Data for the previous index returns this cycle.
                if (idx_q != 8'd0) begin
                    oam_we_o  = 1'b1;
                    oam_idx_o = idx_q - 8'd1;
                end
                if (idx_q == OAM_LAST) state_d = DRAIN;
                else                   idx_d   = idx_q + 8'd1;
            end
            DRAIN: begin
                oam_we_o  = 1'b1;
                oam_idx_o = OAM_LAST;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_i) begin
            state_d = START;
            src_d   = src_i;
            idx_d   = '0;
        end
    end

    assign active_o = (state_q != IDLE);

endmodule

// File: rtl/ppu_mem_responder.sv
// VRAM/OAM owner answering PPU fetches, CPU MMIO accesses and OAM DMA.
// Define MODE_LOCK_EN to lock CPU access by PPU mode.
module ppu_mem_responder
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        PPU_RD,
    input  logic [15:0] PPU_ADDR,
    output logic [7:0]  PPU_DATA,
    input  logic [1:0]  PPU_MODE,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic        RD,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  MMIO_DATA_in,
    output logic        DMA_RD,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DATA,
    output logic        DMA_ACTIVE
);

    logic [7:0] vram_q [VRAM_LEN];
    logic [7:0] oam_q  [OAM_LEN];

    logic [7:0] ppu_data_q, ppu_data_d;
    logic [7:0] mmio_q, mmio_d;

    logic       dma_start, dma_we;
    logic [7:0] dma_idx, dma_wdata;
    logic       vram_lock, oam_lock;
    logic       cpu_vram, cpu_oam, ppu_vram, ppu_oam;
    logic       vram_wr, oam_wr;

    assign dma_start = WR && (ADDR == DMA_REG_ADDR);

    oam_dma_engine u_dma (
        .clk         (clk),
        .rst         (rst),
        .start_i     (dma_start),
        .src_i       (MMIO_DATA_out),
        .dma_data_i  (DMA_DATA),
        .dma_rd_o    (DMA_RD),
        .dma_addr_o  (DMA_ADDR),
        .active_o    (DMA_ACTIVE),
        .oam_we_o    (dma_we),
        .oam_idx_o   (dma_idx),
        .oam_wdata_o (dma_wdata)
    );

`ifdef MODE_LOCK_EN
    ppu_mode_e mode;
    assign mode      = ppu_mode_e'(PPU_MODE);
    assign vram_lock = (mode == DRAW);
    assign oam_lock  = (mode == SCAN) || (mode == DRAW) || DMA_ACTIVE;
`else
    logic unused_mode;
    assign unused_mode = ^PPU_MODE;
    assign vram_lock   = 1'b0;
    assign oam_lock    = DMA_ACTIVE;
`endif

    // OAM base has a zero low byte, so the low address byte is the OAM index.
    assign cpu_vram = in_vram(ADDR);
    assign cpu_oam  = in_oam(ADDR);
    assign ppu_vram = in_vram(PPU_ADDR);
    assign ppu_oam  = in_oam(PPU_ADDR);
    assign vram_wr  = WR && cpu_vram && !vram_lock;
    assign oam_wr   = WR && cpu_oam && !oam_lock;

    always_ff @(posedge clk) begin
        if (vram_wr) vram_q[ADDR[12:0]] <= MMIO_DATA_out;
        if (dma_we)      oam_q[dma_idx]    <= dma_wdata;
        else if (oam_wr) oam_q[ADDR[7:0]]  <= MMIO_DATA_out;
    end

    always_comb begin
        ppu_data_d = ppu_data_q;
        if (PPU_RD) begin
            if (ppu_vram)                    ppu_data_d = vram_q[PPU_ADDR[12:0]];
            else if (ppu_oam && !DMA_ACTIVE) ppu_data_d = oam_q[PPU_ADDR[7:0]];
            else                             ppu_data_d = 8'hFF;
        end

        mmio_d = 8'hFF;
        if (RD && cpu_vram && !vram_lock)   mmio_d = vram_q[ADDR[12:0]];
        else if (RD && cpu_oam && !oam_lock) mmio_d = oam_q[ADDR[7:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ppu_data_q <= 8'hFF;
            mmio_q     <= 8'hFF;
        end else begin
            ppu_data_q <= ppu_data_d;
            mmio_q     <= mmio_d;
        end
    end

    assign PPU_DATA     = ppu_data_q;
    assign MMIO_DATA_in = mmio_q;

endmodule
